// File: rtl/icache.sv
// ============================================================================
//  Module   : icache
//  Purpose  : Direct-mapped, one-word-per-frame instruction cache with a
//             two-state miss FSM and saturating hit/miss statistics.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache #(
  parameter int SETS  = 16,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             imemREN,
  input  logic [31:0]      imemaddr,
  output logic [31:0]      imemload,
  output logic             ihit,
  output logic             iREN,
  output logic [31:0]      iaddr,
  input  logic [31:0]      iload,
  input  logic             iwait,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - IDX_W - 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       miss_addr_q, miss_addr_d;
  logic [SETS-1:0]   valid_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [31:0]       data_q [SETS];
  logic [CNT_W-1:0]  hit_count_q, hit_count_d;
  logic [CNT_W-1:0]  miss_count_q, miss_count_d;

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic [IDX_W-1:0]  w_fill_idx;
  logic [TAG_W-1:0]  w_fill_tag;
  logic              w_hit;
  logic              w_miss;
  logic              w_fill;
  logic              w_unused_offset;

  assign w_idx           = imemaddr[IDX_W+1:2];
  assign w_tag           = imemaddr[31:IDX_W+2];
  assign w_fill_idx      = miss_addr_q[IDX_W+1:2];
  assign w_fill_tag      = miss_addr_q[31:IDX_W+2];
  assign w_unused_offset = ^imemaddr[1:0];

  assign w_hit = imemREN & valid_q[w_idx] & (tag_q[w_idx] == w_tag);

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    ihit        = 1'b0;
    imemload    = 32'h0;
    iREN        = 1'b0;
    iaddr       = 32'h0;
    w_miss      = 1'b0;
    w_fill      = 1'b0;
    case (state_q)
      IDLE: begin
        ihit = w_hit;
        if (w_hit) begin
          imemload = data_q[w_idx];
        end
        if (imemREN && !w_hit) begin
          miss_addr_d = {imemaddr[31:2], 2'b00};
          w_miss      = 1'b1;
          state_d     = FILL;
        end
      end
      FILL: begin
        // Serves the latched miss address regardless of what IF presents now.
        iREN  = 1'b1;
        iaddr = miss_addr_q;
        if (!iwait) begin
          w_fill  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (ihit && (hit_count_q != {CNT_W{1'b1}})) begin
      hit_count_d = hit_count_q + CNT_W'(1);
    end
    if (w_miss && (miss_count_q != {CNT_W{1'b1}})) begin
      miss_count_d = miss_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      miss_addr_q  <= 32'h0;
      valid_q      <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      miss_addr_q  <= miss_addr_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      if (w_fill) begin
        valid_q[w_fill_idx] <= 1'b1;
      end
    end
  end

  // Tag/data need no reset: valid gates every use of them.
  always_ff @(posedge CLK) begin
    if (w_fill) begin
      tag_q[w_fill_idx]  <= w_fill_tag;
      data_q[w_fill_idx] <= iload;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule

`default_nettype wire

// File: tb/tb_icache.sv
// ============================================================================
//  Module   : tb_icache
//  Purpose  : Directed self-checking bench for icache.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_icache;

  logic        CLK;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic [31:0] imemload;
  logic        ihit;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int n_vec;
  int n_err;

  icache #(.SETS(16), .CNT_W(32)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .imemload   (imemload),
    .ihit       (ihit),
    .iREN       (iREN),
    .iaddr      (iaddr),
    .iload      (iload),
    .iwait      (iwait),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // Full miss sequence: miss cycle, n wait cycles, one fill cycle, then hit.
  task automatic do_miss(input logic [31:0] a, input logic [31:0] d, input int n);
    imemREN  = 1'b1;
    imemaddr = a;
    iwait    = 1'b1;
    iload    = 32'hBAD0_BAD0;
    @(negedge CLK);
    check("miss_ihit", {31'h0, ihit}, 32'h0);
    check("miss_iREN", {31'h0, iREN}, 32'h0);
    next_cycle();
    for (int i = 0; i <= n; i++) begin
      iwait = (i < n);
      iload = (i == n) ? d : 32'hBAD0_BAD0;
      @(negedge CLK);
      check("fill_iREN", {31'h0, iREN}, 32'h1);
      check("fill_iaddr", iaddr, {a[31:2], 2'b00});
      next_cycle();
    end
    iwait = 1'b1;
    @(negedge CLK);
    check("refetch_ihit", {31'h0, ihit}, 32'h1);
    check("refetch_data", imemload, d);
    next_cycle();
  endtask

  task automatic expect_hit(input logic [31:0] a, input logic [31:0] d);
    imemREN  = 1'b1;
    imemaddr = a;
    @(negedge CLK);
    check("hit_ihit", {31'h0, ihit}, 32'h1);
    check("hit_data", imemload, d);
    check("hit_iREN", {31'h0, iREN}, 32'h0);
    next_cycle();
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    RST      = 1'b1;
    imemREN  = 1'b1;
    imemaddr = 32'hDEAD_BEEF;
    iwait    = 1'b0;
    iload    = 32'hCAFE_F00D;

    // Reset with garbage inputs
    @(negedge CLK);
    check("rst_ihit", {31'h0, ihit}, 32'h0);
    check("rst_iREN", {31'h0, iREN}, 32'h0);
    check("rst_iaddr", iaddr, 32'h0);
    check("rst_imemload", imemload, 32'h0);
    check("rst_hits", hit_count, 32'h0);
    check("rst_misses", miss_count, 32'h0);
    next_cycle();
    RST = 1'b0;

    // Cold miss, 3 wait cycles
    do_miss(32'h0000_0044, 32'h2402_0005, 3);
    check("cold_misses", miss_count, 32'd1);
    check("cold_hits", hit_count, 32'd1);

    // Hit stream; offset bits ignored
    do_miss(32'h0000_0000, 32'h1111_1111, 0);
    do_miss(32'h0000_0004, 32'h2222_2222, 1);
    do_miss(32'h0000_0008, 32'h3333_3333, 2);
    expect_hit(32'h0000_0000, 32'h1111_1111);
    expect_hit(32'h0000_0005, 32'h2222_2222);
    expect_hit(32'h0000_0008, 32'h3333_3333);
    check("stream_hits", hit_count, 32'd7);
    check("stream_misses", miss_count, 32'd4);

    // No request: no hit, no data, no count
    imemREN  = 1'b0;
    imemaddr = 32'h0000_0000;
    @(negedge CLK);
    check("noreq_ihit", {31'h0, ihit}, 32'h0);
    check("noreq_data", imemload, 32'h0);
    next_cycle();
    check("noreq_hits", hit_count, 32'd7);
    check("noreq_misses", miss_count, 32'd4);

    // Conflict on index 0
    do_miss(32'h0000_0040, 32'hBBBB_0040, 1);
    expect_hit(32'h0000_0040, 32'hBBBB_0040);
    do_miss(32'h0000_0000, 32'hAAAA_0000, 0);
    do_miss(32'h0000_0040, 32'hBBBB_0040, 0);
    check("conf_misses", miss_count, 32'd7);
    check("conf_hits", hit_count, 32'd11);

    // Address moves during FILL
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0010;
    iwait    = 1'b1;
    @(negedge CLK);
    check("mv_miss_ihit", {31'h0, ihit}, 32'h0);
    next_cycle();
    imemaddr = 32'h0000_0020;
    @(negedge CLK);
    check("mv_wait_iaddr", iaddr, 32'h0000_0010);
    check("mv_wait_ihit", {31'h0, ihit}, 32'h0);
    next_cycle();
    iwait = 1'b0;
    iload = 32'h5555_5555;
    @(negedge CLK);
    check("mv_fill_iaddr", iaddr, 32'h0000_0010);
    next_cycle();
    iwait = 1'b1;
    @(negedge CLK);
    check("mv_new_ihit", {31'h0, ihit}, 32'h0);
    check("mv_new_iREN", {31'h0, iREN}, 32'h0);
    next_cycle();
    @(negedge CLK);
    check("mv_new_iaddr", iaddr, 32'h0000_0020);
    next_cycle();
    iwait = 1'b0;
    iload = 32'h6666_6666;
    next_cycle();
    iwait = 1'b1;
    expect_hit(32'h0000_0020, 32'h6666_6666);
    expect_hit(32'h0000_0010, 32'h5555_5555);
    check("mv_misses", miss_count, 32'd9);
    check("mv_hits", hit_count, 32'd13);

    // Reset during FILL
    imemaddr = 32'h0000_0080;
    @(negedge CLK);
    check("rf_miss_ihit", {31'h0, ihit}, 32'h0);
    next_cycle();
    @(negedge CLK);
    check("rf_fill_iREN", {31'h0, iREN}, 32'h1);
    #2;
    RST = 1'b1;
    #1;
    check("rf_async_iREN", {31'h0, iREN}, 32'h0);
    check("rf_async_iaddr", iaddr, 32'h0);
    iwait = 1'b0;
    iload = 32'h7777_7777;
    next_cycle();
    check("rf_hits", hit_count, 32'h0);
    check("rf_misses", miss_count, 32'h0);
    RST = 1'b0;
    @(negedge CLK);
    check("rf_cold_ihit", {31'h0, ihit}, 32'h0);
    next_cycle();
    check("rf_cold_miss", miss_count, 32'd1);
    next_cycle();
    imemaddr = 32'h0000_0044;
    @(negedge CLK);
    check("rf_old_ihit", {31'h0, ihit}, 32'h0);
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
